// File: rtl/pflink_rx_deframer_pkg.sv
// Shared definitions for the PF link receive deframer: control characters,
// frame_err bit positions, FSM states and the per-word classifier.
package pflink_rx_deframer_pkg;

    localparam logic [7:0] COMMA = 8'hBC;
    localparam logic [7:0] PAD   = 8'h1C;
    localparam logic [7:0] IDLE  = 8'hF7;

    localparam int ERR_ABORT = 0;
    localparam int ERR_CKSUM = 1;
    localparam int ERR_SEQ   = 2;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        TRAILER = 2'd2
    } deframer_state_e;

    typedef enum logic [1:0] {
        WORD_HDR  = 2'd0,
        WORD_DATA = 2'd1,
        WORD_FILL = 2'd2,
        WORD_BAD  = 2'd3
    } word_class_e;

    // A word only has a class when the receiver vouches for it (v=1);
    // anything the receiver could not decode is treated as corruption.
    function automatic word_class_e classify_word(input logic [7:0] byte0,
                                                  input logic [3:0] k,
                                                  input logic       v);
        word_class_e cls;
        if (!v) begin
            cls = WORD_BAD;
        end else if ((k == 4'b0001) && (byte0 == COMMA)) begin
            cls = WORD_HDR;
        end else if (k == 4'b0000) begin
            cls = WORD_DATA;
        end else if (k == 4'b1111) begin
            cls = WORD_FILL;
        end else begin
            cls = WORD_BAD;
        end
        return cls;
    endfunction

endpackage

// File: rtl/pflink_rx_deframer_sat_counter.sv
// Saturating event counter for the status bank. A clear request takes
// priority over a simultaneous increment.
module pflink_rx_deframer_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_link,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Count events, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk_link or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pflink_rx_deframer.sv
// PF optical link receive deframer: hunts for COMMA-headed frames, forwards
// payload with SOF/EOF, checks the additive checksum and sequence number,
// and maintains alignment status plus error counters.
module pflink_rx_deframer
    import pflink_rx_deframer_pkg::*;
#(
    parameter int NUM_WORDS    = 8,
    parameter int ALIGN_THRESH = 4
) (
    input  logic        clk_link,
    input  logic        reset_n,
    input  logic [31:0] rx_d,
    input  logic [3:0]  rx_k,
    input  logic        rx_v,
    input  logic        counter_reset,
    output logic [31:0] out_d,
    output logic        out_v,
    output logic        out_sof,
    output logic        out_eof,
    output logic [7:0]  hdr_tag,
    output logic [15:0] hdr_seq,
    output logic        frame_done,
    output logic [2:0]  frame_err,
    output logic        link_aligned,
    output logic [31:0] cnt_ok,
    output logic [31:0] cnt_bad,
    output logic [15:0] cnt_seq
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);
    localparam logic [3:0] THRESH   = 4'(ALIGN_THRESH);

    deframer_state_e state_r, state_s;
    word_class_e     cls_s;
    logic            capture_s, data_s, close_s, abort_s, done_s;
    logic [2:0]      err_s;
    logic [7:0]      cnt_r;
    logic [31:0]     sum_r;
    logic [15:0]     last_seq_r;
    logic            seq_valid_r;
    logic [3:0]      clean_r;

    // Classify the word on the link this cycle.
    always_comb begin
        cls_s = classify_word(rx_d[7:0], rx_k, rx_v);
    end

    // Next-state and per-word actions. A header inside a frame both aborts
    // the old frame and opens the new one.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        data_s    = 1'b0;
        close_s   = 1'b0;
        abort_s   = 1'b0;
        err_s     = 3'b000;
        case (state_r)
            HUNT: begin
                if (cls_s == WORD_HDR) begin
                    capture_s = 1'b1;
                    state_s   = PAYLOAD;
                end else begin
                    state_s = HUNT;
                end
            end
            PAYLOAD, TRAILER: begin
                case (cls_s)
                    WORD_HDR: begin
                        abort_s   = 1'b1;
                        capture_s = 1'b1;
                        state_s   = PAYLOAD;
                    end
                    WORD_DATA: begin
                        if (state_r == PAYLOAD) begin
                            data_s = 1'b1;
                            if (cnt_r == LAST_IDX) begin
                                state_s = TRAILER;
                            end else begin
                                state_s = PAYLOAD;
                            end
                        end else begin
                            close_s          = 1'b1;
                            err_s[ERR_CKSUM] = (rx_d != sum_r);
                            err_s[ERR_SEQ]   = seq_valid_r && (hdr_seq != (last_seq_r + 16'd1));
                            state_s          = HUNT;
                        end
                    end
                    WORD_FILL: begin
                        state_s = state_r;
                    end
                    default: begin
                        abort_s = 1'b1;
                        state_s = HUNT;
                    end
                endcase
                err_s[ERR_ABORT] = abort_s;
            end
            default: begin
                state_s = HUNT;
            end
        endcase
        done_s = abort_s | close_s;
    end

    // FSM state register.
    always_ff @(posedge clk_link or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= HUNT;
        end else begin
            state_r <= state_s;
        end
    end

    // Header capture, running checksum, word index and last good sequence.
    // The sequence history only advances on frames that reach their trailer.
    always_ff @(posedge clk_link or negedge reset_n) begin
        if (!reset_n) begin
            hdr_tag     <= 8'h00;
            hdr_seq     <= 16'h0000;
            sum_r       <= 32'h0000_0000;
            cnt_r       <= 8'h00;
            last_seq_r  <= 16'h0000;
            seq_valid_r <= 1'b0;
        end else begin
            if (capture_s) begin
                hdr_tag <= rx_d[15:8];
                hdr_seq <= rx_d[31:16];
                sum_r   <= 32'h0000_0000;
                cnt_r   <= 8'h00;
            end else if (data_s) begin
                sum_r <= sum_r + rx_d;
                cnt_r <= cnt_r + 8'd1;
            end
            if (close_s) begin
                last_seq_r  <= hdr_seq;
                seq_valid_r <= 1'b1;
            end
        end
    end

    // Registered payload stream and frame-close status.
    always_ff @(posedge clk_link or negedge reset_n) begin
        if (!reset_n) begin
            out_d      <= 32'h0000_0000;
            out_v      <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 3'b000;
        end else begin
            if (data_s) begin
                out_d <= rx_d;
            end
            out_v      <= data_s;
            out_sof    <= data_s && (cnt_r == 8'h00);
            out_eof    <= data_s && (cnt_r == LAST_IDX);
            frame_done <= done_s;
            frame_err  <= err_s;
        end
    end

    // Alignment tracking: updates together with frame_done so that an
    // errored frame drops link_aligned in the very cycle it is reported.
    always_ff @(posedge clk_link or negedge reset_n) begin
        if (!reset_n) begin
            clean_r      <= 4'h0;
            link_aligned <= 1'b0;
        end else if (done_s) begin
            if (err_s != 3'b000) begin
                clean_r      <= 4'h0;
                link_aligned <= 1'b0;
            end else if (clean_r < THRESH) begin
                clean_r      <= clean_r + 4'd1;
                link_aligned <= ((clean_r + 4'd1) == THRESH);
            end
        end
    end

    // Counters advance during the frame_done cycle, so a counter_reset in
    // that same cycle discards the increment.
    pflink_rx_deframer_sat_counter #(.W(32)) u_cnt_ok (
        .clk_link (clk_link),
        .reset_n  (reset_n),
        .clear    (counter_reset),
        .inc      (frame_done && (frame_err == 3'b000)),
        .count    (cnt_ok)
    );

    pflink_rx_deframer_sat_counter #(.W(32)) u_cnt_bad (
        .clk_link (clk_link),
        .reset_n  (reset_n),
        .clear    (counter_reset),
        .inc      (frame_done && (frame_err != 3'b000)),
        .count    (cnt_bad)
    );

    pflink_rx_deframer_sat_counter #(.W(16)) u_cnt_seq (
        .clk_link (clk_link),
        .reset_n  (reset_n),
        .clear    (counter_reset),
        .inc      (frame_done && frame_err[ERR_SEQ]),
        .count    (cnt_seq)
    );

endmodule

// File: tb/tb_pflink_rx_deframer.sv
// Scoreboard bench for pflink_rx_deframer: directed frame scenarios followed
// by randomized frame streams, checked against a frame-level model.
module tb_pflink_rx_deframer;
    import pflink_rx_deframer_pkg::*;

    localparam int NW = 8;
    localparam int AT = 4;

    logic        clk_link = 1'b0;
    logic        reset_n;
    logic [31:0] rx_d;
    logic [3:0]  rx_k;
    logic        rx_v;
    logic        counter_reset;
    logic [31:0] out_d;
    logic        out_v, out_sof, out_eof;
    logic [7:0]  hdr_tag;
    logic [15:0] hdr_seq;
    logic        frame_done;
    logic [2:0]  frame_err;
    logic        link_aligned;
    logic [31:0] cnt_ok, cnt_bad;
    logic [15:0] cnt_seq;

    always #5 clk_link = ~clk_link;

    pflink_rx_deframer #(.NUM_WORDS(NW), .ALIGN_THRESH(AT)) dut (
        .clk_link(clk_link), .reset_n(reset_n), .rx_d(rx_d), .rx_k(rx_k), .rx_v(rx_v),
        .counter_reset(counter_reset), .out_d(out_d), .out_v(out_v), .out_sof(out_sof),
        .out_eof(out_eof), .hdr_tag(hdr_tag), .hdr_seq(hdr_seq), .frame_done(frame_done),
        .frame_err(frame_err), .link_aligned(link_aligned), .cnt_ok(cnt_ok),
        .cnt_bad(cnt_bad), .cnt_seq(cnt_seq)
    );

    typedef struct {
        logic [31:0] d;
        logic        sof;
        logic        eof;
    } beat_t;

    typedef struct {
        logic [2:0]  err;
        logic        aligned;
        logic [7:0]  tag;
        logic [15:0] seq;
        logic [31:0] ok_before;
        logic [31:0] bad_before;
        logic [15:0] seqc_before;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // Frame-level reference state
    logic [15:0] m_last_seq;
    bit          m_seq_valid;
    int          m_clean;
    logic [31:0] m_ok, m_bad;
    logic [15:0] m_seqc;
    bit          pending_abort;
    logic [15:0] t3_seq [5] = '{16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0002};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Model of one closed frame: counters are recorded as seen during frame_done
    function automatic void close_frame(input logic [2:0] err, input logic [7:0] tag, input logic [15:0] seq);
        done_t r;
        r.err = err; r.tag = tag; r.seq = seq;
        r.ok_before = m_ok; r.bad_before = m_bad; r.seqc_before = m_seqc;
        if (err == 3'b000) begin
            m_clean = (m_clean < AT) ? m_clean + 1 : AT;
            if (m_ok != 32'hFFFF_FFFF) m_ok = m_ok + 32'd1;
        end else begin
            m_clean = 0;
            if (m_bad != 32'hFFFF_FFFF) m_bad = m_bad + 32'd1;
            if (err[2] && (m_seqc != 16'hFFFF)) m_seqc = m_seqc + 16'd1;
        end
        r.aligned = (m_clean == AT);
        done_q.push_back(r);
    endfunction

    task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic v);
        @(negedge clk_link);
        rx_d = d; rx_k = k; rx_v = v;
    endtask

    task automatic send_fill();
        logic [31:0] w;
        w = ($urandom_range(0, 1) == 0) ? {PAD, PAD, PAD, PAD} : {IDLE, IDLE, IDLE, IDLE};
        drive(w, 4'b1111, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_fill();
    endtask

    task automatic send_bad();
        if ($urandom_range(0, 1) == 0) drive($urandom, 4'($urandom_range(0, 15)), 1'b0);
        else drive($urandom, 4'b0010, 1'b1);
    endtask

    // kind: 0 good, 1 bad checksum, 2 aborted by a BAD word,
    // 3 aborted by the next frame's header, 4 left open (cut by reset)
    task automatic send_frame(input int kind, input logic [15:0] seq, input logic [7:0] tag,
                              input int n_data, input bit rnd);
        logic [31:0] sum, w, trailer;
        logic [2:0]  err;
        beat_t       b;
        int          gap;
        if (!pending_abort) begin
            gap = rnd ? $urandom_range(0, 3) : 1;
            for (int i = 0; i < gap; i++) begin
                case ($urandom_range(0, 2))
                    0:       drive($urandom, 4'b0000, 1'b1);
                    1:       send_bad();
                    default: send_fill();
                endcase
            end
        end
        drive({seq, tag, COMMA}, 4'b0001, 1'b1);
        if (pending_abort) begin
            close_frame(3'b001, tag, seq);
            pending_abort = 1'b0;
        end
        sum = 32'h0;
        for (int i = 0; i < n_data; i++) begin
            if (rnd && ($urandom_range(0, 4) == 0)) send_fill();
            w = rnd ? $urandom : 32'(i + 1);
            drive(w, 4'b0000, 1'b1);
            sum = sum + w;
            b.d = w; b.sof = (i == 0); b.eof = (i == NW - 1);
            beat_q.push_back(b);
        end
        case (kind)
            0, 1: begin
                if (rnd && ($urandom_range(0, 3) == 0)) send_fill();
                err    = 3'b000;
                err[1] = (kind == 1);
                err[2] = m_seq_valid && (seq != (m_last_seq + 16'd1));
                trailer = (kind == 1) ? sum + (rnd ? 32'($urandom_range(1, 255)) : 32'd1) : sum;
                drive(trailer, 4'b0000, 1'b1);
                close_frame(err, tag, seq);
                m_last_seq  = seq;
                m_seq_valid = 1'b1;
            end
            2: begin
                send_bad();
                close_frame(3'b001, tag, seq);
            end
            3: pending_abort = 1'b1;
            default: ;
        endcase
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_out_d"}, out_d, 32'h0);
        check({tag, "_out_flags"}, {29'h0, out_v, out_sof, out_eof}, 32'h0);
        check({tag, "_done_err"}, {28'h0, frame_done, frame_err}, 32'h0);
        check({tag, "_aligned"}, {31'h0, link_aligned}, 32'h0);
        check({tag, "_hdr"}, {8'h0, hdr_tag, hdr_seq}, 32'h0);
        check({tag, "_cnt_ok"}, cnt_ok, 32'h0);
        check({tag, "_cnt_bad"}, cnt_bad, 32'h0);
        check({tag, "_cnt_seq"}, {16'h0, cnt_seq}, 32'h0);
    endtask

    task automatic apply_reset();
        @(negedge clk_link);
        #2;
        reset_n = 1'b0;
        counter_reset = 1'b0;
        rx_d = {IDLE, IDLE, IDLE, IDLE}; rx_k = 4'b1111; rx_v = 1'b1;
        #1;
        check_outputs_zero("rst_async");
        @(negedge clk_link);
        @(negedge clk_link);
        check_outputs_zero("rst_held");
        reset_n = 1'b1;
        m_last_seq = 16'h0; m_seq_valid = 1'b0; m_clean = 0;
        m_ok = 32'h0; m_bad = 32'h0; m_seqc = 16'h0; pending_abort = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        idle(2);
        check({tag, "_cnt_ok"}, cnt_ok, m_ok);
        check({tag, "_cnt_bad"}, cnt_bad, m_bad);
        check({tag, "_cnt_seq"}, {16'h0, cnt_seq}, {16'h0, m_seqc});
        check({tag, "_aligned"}, {31'h0, link_aligned}, {31'h0, (m_clean == AT)});
    endtask

    task automatic check_queues_empty(input string tag);
        check({tag, "_beats_left"}, 32'(beat_q.size()), 32'h0);
        check({tag, "_frames_left"}, 32'(done_q.size()), 32'h0);
    endtask

    // Monitor: pops an expectation whenever the DUT presents a beat or closes a frame
    initial begin : monitor
        beat_t b;
        done_t r;
        forever begin
            @(negedge clk_link);
            if (reset_n) begin
                if (out_v) begin
                    if (beat_q.size() == 0) begin
                        check("unexpected_out_v", {31'h0, out_v}, 32'h0);
                    end else begin
                        b = beat_q.pop_front();
                        check("out_d", out_d, b.d);
                        check("out_sof_eof", {30'h0, out_sof, out_eof}, {30'h0, b.sof, b.eof});
                    end
                end else if (out_sof || out_eof) begin
                    check("sof_eof_without_v", {30'h0, out_sof, out_eof}, 32'h0);
                end
                if (frame_done) begin
                    if (done_q.size() == 0) begin
                        check("unexpected_frame_done", {31'h0, frame_done}, 32'h0);
                    end else begin
                        r = done_q.pop_front();
                        check("frame_err", {29'h0, frame_err}, {29'h0, r.err});
                        check("link_aligned", {31'h0, link_aligned}, {31'h0, r.aligned});
                        check("hdr_tag_seq", {8'h0, hdr_tag, hdr_seq}, {8'h0, r.tag, r.seq});
                        check("cnt_ok_at_done", cnt_ok, r.ok_before);
                        check("cnt_bad_at_done", cnt_bad, r.bad_before);
                        check("cnt_seq_at_done", {16'h0, cnt_seq}, {16'h0, r.seqc_before});
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int kind;
        logic [15:0] s;
        reset_n = 1'b0;
        counter_reset = 1'b0;
        rx_d = {IDLE, IDLE, IDLE, IDLE}; rx_k = 4'b1111; rx_v = 1'b1;
        pending_abort = 1'b0;
        apply_reset();

        // Clean frame with payload 1..8, then the same frame with a bad trailer
        send_frame(0, 16'h0010, 8'h5A, NW, 1'b0);
        check_counters("t1");
        send_frame(1, 16'h0011, 8'h5B, NW, 1'b0);
        check_counters("t2");

        // Sequence wrap FFFF->0000, then a skipped number
        apply_reset();
        foreach (t3_seq[i]) begin
            send_frame(0, t3_seq[i], 8'(8'h30 + i), NW, 1'b0);
            check_counters("t3");
        end

        // Abort by a bad word, then by a fresh header
        send_frame(2, m_last_seq + 16'd1, 8'h41, 3, 1'b0);
        send_frame(0, m_last_seq + 16'd1, 8'h42, NW, 1'b0);
        check_counters("t4");
        send_frame(3, m_last_seq + 16'd1, 8'h51, 3, 1'b0);
        send_frame(0, m_last_seq + 16'd1, 8'h52, NW, 1'b0);
        check_counters("t5");

        // Reset mid-payload, saturation and counter_reset during frame_done
        send_frame(4, m_last_seq + 16'd1, 8'h61, 3, 1'b0);
        idle(1);
        apply_reset();
        check_queues_empty("t6_reset");
        force dut.u_cnt_ok.count = 32'hFFFF_FFFF;
        idle(1);
        release dut.u_cnt_ok.count;
        m_ok = 32'hFFFF_FFFF;
        send_frame(0, 16'h0100, 8'h62, NW, 1'b0);
        check_counters("t6_sat");
        send_frame(1, 16'h0101, 8'h63, NW, 1'b0);
        @(negedge clk_link);
        counter_reset = 1'b1;
        @(negedge clk_link);
        counter_reset = 1'b0;
        m_ok = 32'h0; m_bad = 32'h0; m_seqc = 16'h0;
        check_counters("t6_clr");

        // Randomized frame stream
        for (int f = 0; f < 150; f++) begin
            kind = $urandom_range(0, 99);
            kind = (kind < 50) ? 0 : (kind < 65) ? 1 : (kind < 80) ? 2 : 3;
            if (f == 149) kind = 0;
            s = ($urandom_range(0, 4) == 0) ? 16'($urandom) : m_last_seq + 16'd1;
            send_frame(kind, s, 8'($urandom), (kind < 2) ? NW : $urandom_range(0, NW), 1'b1);
        end
        check_counters("rand");
        check_queues_empty("end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
